// File: rtl/regfile_pkg.sv
// Shared definitions for the multi-port register file: default sizes, address
// width helper, data/address typedefs and the write-port selection record.
package regfile_pkg;

  localparam int XLEN_DEF = 64;
  localparam int NREG_DEF = 32;

  function automatic int addrWidth(input int nreg);
    return (nreg > 1) ? $clog2(nreg) : 1;
  endfunction

  localparam int AW_DEF = addrWidth(NREG_DEF);

  localparam logic [XLEN_DEF-1:0] ZERO_WORD = '0;

  typedef logic [AW_DEF-1:0]   reg_addr_t;
  typedef logic [XLEN_DEF-1:0] reg_data_t;

  // Result of write-port arbitration for one register address (up to 4 ports)
  typedef struct packed {
    logic       hit;
    logic [1:0] port;
  } wr_sel_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy scoreboard: issue marks a destination busy, writeback clears it,
// flush clears everything. Produces the WAW issue check and the raw busy vector.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int  NREG    = NREG_DEF,
  parameter bit  ZERO_R0 = 1'b1,
  localparam int AW      = addrWidth(NREG)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush_i,
  input  logic            iss_en_i,
  input  logic [AW-1:0]   iss_addr_i,
  input  logic [NREG-1:0] wr_hit_i,
  output logic            iss_ok_o,
  output logic [NREG-1:0] busy_vec_o
);

  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_d;

  // Issue beats writeback on the same register so the new producer stays tracked
  always_comb begin
    busy_d = busy_q;
    for (int r = 0; r < NREG; r++) begin
      if (flush_i) begin
        busy_d[r] = 1'b0;
      end else if (iss_en_i && iss_addr_i == AW'(r) && !(ZERO_R0 && r == 0)) begin
        busy_d[r] = 1'b1;
      end else if (wr_hit_i[r]) begin
        busy_d[r] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign iss_ok_o   = (ZERO_R0 && iss_addr_i == '0) || !busy_q[iss_addr_i] || wr_hit_i[iss_addr_i];
  assign busy_vec_o = busy_q;

  issueWhileBusy: assert property (@(posedge clk) disable iff (rst) iss_en_i |-> iss_ok_o);

endmodule

// File: rtl/regfile_mp_sb.sv
// Multi-port integer register file with optional write-to-read bypass and a busy
// scoreboard used by decode for RAW stalls and WAW issue checks.
module regfile_mp_sb
  import regfile_pkg::*;
#(
  parameter int  XLEN    = XLEN_DEF,
  parameter int  NREG    = NREG_DEF,
  parameter int  NRD     = 2,
  parameter int  NWR     = 1,
  parameter bit  BYPASS  = 1'b1,
  parameter bit  ZERO_R0 = 1'b1,
  localparam int AW      = addrWidth(NREG)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NRD*AW-1:0]   rd_addr_i,
  output logic [NRD*XLEN-1:0] rd_data_o,
  output logic [NRD-1:0]      rd_busy_o,
  input  logic [NWR-1:0]      wr_en_i,
  input  logic [NWR*AW-1:0]   wr_addr_i,
  input  logic [NWR*XLEN-1:0] wr_data_i,
  input  logic                iss_en_i,
  input  logic [AW-1:0]       iss_addr_i,
  output logic                iss_ok_o,
  input  logic                flush_i,
  output logic [NREG-1:0]     busy_vec_o
);

  logic [XLEN-1:0] arr_q [NREG];
  logic [XLEN-1:0] arr_d [NREG];
  logic [NREG-1:0] wrHit;

  // Highest-index enabled port targeting the address wins; r0 never matches when hard-wired
  function automatic wr_sel_t selWriter(input logic [NWR-1:0]    en,
                                        input logic [NWR*AW-1:0] addrs,
                                        input logic [AW-1:0]     a);
    wr_sel_t s;
    s.hit  = 1'b0;
    s.port = '0;
    if (!(ZERO_R0 && a == '0)) begin
      for (int j = 0; j < NWR; j++) begin
        if (en[j] && addrs[j*AW +: AW] == a) begin
          s.hit  = 1'b1;
          s.port = 2'(j);
        end
      end
    end
    return s;
  endfunction

  always_comb begin
    wr_sel_t sel;
    wrHit = '0;
    for (int r = 0; r < NREG; r++) begin
      sel      = selWriter(wr_en_i, wr_addr_i, AW'(r));
      arr_d[r] = arr_q[r];
      wrHit[r] = sel.hit;
      if (sel.hit) begin
        arr_d[r] = wr_data_i[int'(sel.port)*XLEN +: XLEN];
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int r = 0; r < NREG; r++) begin
      if (rst) begin
        arr_q[r] <= '0;
      end else begin
        arr_q[r] <= arr_d[r];
      end
    end
  end

  // A same-cycle write both forwards its data and satisfies the pending producer
  always_comb begin
    logic [AW-1:0] a;
    wr_sel_t       sel;
    rd_data_o = '0;
    rd_busy_o = '0;
    for (int i = 0; i < NRD; i++) begin
      a   = rd_addr_i[i*AW +: AW];
      sel = selWriter(wr_en_i, wr_addr_i, a);
      if (!(ZERO_R0 && a == '0)) begin
        if (BYPASS && sel.hit) begin
          rd_data_o[i*XLEN +: XLEN] = wr_data_i[int'(sel.port)*XLEN +: XLEN];
        end else begin
          rd_data_o[i*XLEN +: XLEN] = arr_q[a];
        end
        rd_busy_o[i] = busy_vec_o[a] && !(BYPASS && sel.hit);
      end
    end
  end

  regfile_scoreboard #(
    .NREG    (NREG),
    .ZERO_R0 (ZERO_R0)
  ) u_scoreboard (
    .clk        (clk),
    .rst        (rst),
    .flush_i    (flush_i),
    .iss_en_i   (iss_en_i),
    .iss_addr_i (iss_addr_i),
    .wr_hit_i   (wrHit),
    .iss_ok_o   (iss_ok_o),
    .busy_vec_o (busy_vec_o)
  );

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Drives a bypassing and a non-bypassing register file with identical stimulus and
// checks both against a reference model through an expected-value queue.
module tb_regfile_mp_sb;

  localparam int XLEN = 64;
  localparam int NREG = 32;
  localparam int AW   = 5;
  localparam int NRD  = 2;
  localparam int NWR  = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                rst;
  logic [NRD*AW-1:0]   rdAddr;
  logic [NRD*XLEN-1:0] rdDataBp, rdDataNb;
  logic [NRD-1:0]      rdBusyBp, rdBusyNb;
  logic [NWR-1:0]      wrEn;
  logic [NWR*AW-1:0]   wrAddr;
  logic [NWR*XLEN-1:0] wrData;
  logic                issEn;
  logic [AW-1:0]       issAddr;
  logic                issOkBp, issOkNb;
  logic                flush;
  logic [NREG-1:0]     busyVecBp, busyVecNb;

  regfile_mp_sb #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .NWR(NWR), .BYPASS(1'b1), .ZERO_R0(1'b1)) dut (
    .clk(clk), .rst(rst), .rd_addr_i(rdAddr), .rd_data_o(rdDataBp), .rd_busy_o(rdBusyBp),
    .wr_en_i(wrEn), .wr_addr_i(wrAddr), .wr_data_i(wrData), .iss_en_i(issEn),
    .iss_addr_i(issAddr), .iss_ok_o(issOkBp), .flush_i(flush), .busy_vec_o(busyVecBp));

  regfile_mp_sb #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .NWR(NWR), .BYPASS(1'b0), .ZERO_R0(1'b1)) dutNb (
    .clk(clk), .rst(rst), .rd_addr_i(rdAddr), .rd_data_o(rdDataNb), .rd_busy_o(rdBusyNb),
    .wr_en_i(wrEn), .wr_addr_i(wrAddr), .wr_data_i(wrData), .iss_en_i(issEn),
    .iss_addr_i(issAddr), .iss_ok_o(issOkNb), .flush_i(flush), .busy_vec_o(busyVecNb));

  typedef struct {
    logic [63:0] d0Bp, d1Bp, d0Nb, d1Nb;
    logic [1:0]  bBp, bNb;
    logic        ok;
    logic [31:0] vec;
  } exp_t;

  exp_t  expQ[$];
  string tagQ[$];

  logic [63:0] mRegs [NREG];
  logic [31:0] mBusy;
  int checks = 0;
  int errors = 0;

  // Model's write arbitration: last enabled port on the address, nothing for r0
  function automatic int winner(input logic [4:0] a);
    int w = -1;
    if (a == 5'd0) return -1;
    if (wrEn[0] && wrAddr[4:0] == a) w = 0;
    if (wrEn[1] && wrAddr[9:5] == a) w = 1;
    return w;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic [4:0] ra0, input logic [4:0] ra1,
                               input logic [1:0] we, input logic [4:0] wa0, input logic [4:0] wa1,
                               input logic [63:0] wd0, input logic [63:0] wd1,
                               input logic ie, input logic [4:0] ia, input logic fl,
                               input logic r, input string tag);
    exp_t e;
    logic [4:0] a;
    int w;
    rdAddr  = {ra1, ra0};
    wrEn    = we;
    wrAddr  = {wa1, wa0};
    wrData  = {wd1, wd0};
    issEn   = ie;
    issAddr = ia;
    flush   = fl;
    rst     = r;
    for (int p = 0; p < 2; p++) begin
      logic [63:0] dBp, dNb;
      a = (p == 1) ? ra1 : ra0;
      w = winner(a);
      dNb = (a == 5'd0) ? 64'd0 : mRegs[a];
      dBp = (w == 0) ? wd0 : (w == 1) ? wd1 : dNb;
      if (p == 0) begin
        e.d0Bp = dBp; e.d0Nb = dNb;
      end else begin
        e.d1Bp = dBp; e.d1Nb = dNb;
      end
      e.bNb[p] = (a != 5'd0) && mBusy[a];
      e.bBp[p] = (a != 5'd0) && mBusy[a] && (w < 0);
    end
    e.ok  = (ia == 5'd0) || !mBusy[ia] || (winner(ia) >= 0);
    e.vec = mBusy;
    expQ.push_back(e);
    tagQ.push_back(tag);
  endtask

  task automatic stepCycle();
    exp_t e;
    string t;
    logic [31:0] nb;
    @(negedge clk);
    if (expQ.size() == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL queue: got empty expected entry");
    end else begin
      e = expQ.pop_front();
      t = tagQ.pop_front();
      checkOutput({t, ".rd0_bp"}, rdDataBp[63:0], e.d0Bp);
      checkOutput({t, ".rd1_bp"}, rdDataBp[127:64], e.d1Bp);
      checkOutput({t, ".rd0_nb"}, rdDataNb[63:0], e.d0Nb);
      checkOutput({t, ".rd1_nb"}, rdDataNb[127:64], e.d1Nb);
      checkOutput({t, ".busy_bp"}, 64'(rdBusyBp), 64'(e.bBp));
      checkOutput({t, ".busy_nb"}, 64'(rdBusyNb), 64'(e.bNb));
      checkOutput({t, ".issok_bp"}, 64'(issOkBp), 64'(e.ok));
      checkOutput({t, ".issok_nb"}, 64'(issOkNb), 64'(e.ok));
      checkOutput({t, ".vec_bp"}, 64'(busyVecBp), 64'(e.vec));
      checkOutput({t, ".vec_nb"}, 64'(busyVecNb), 64'(e.vec));
    end
    // Advance the model with the inputs that the coming posedge will sample
    if (rst) begin
      for (int r = 0; r < NREG; r++) mRegs[r] = '0;
      mBusy = '0;
    end else begin
      nb = mBusy;
      for (int r = 0; r < NREG; r++) begin
        if (flush) nb[r] = 1'b0;
        else if (issEn && issAddr == 5'(r) && r != 0) nb[r] = 1'b1;
        else if (winner(5'(r)) >= 0) nb[r] = 1'b0;
      end
      if (wrEn[0] && wrAddr[4:0] != 5'd0) mRegs[wrAddr[4:0]] = wrData[63:0];
      if (wrEn[1] && wrAddr[9:5] != 5'd0) mRegs[wrAddr[9:5]] = wrData[127:64];
      mBusy = nb;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [4:0]  ra0, ra1, wa0, wa1, ia;
    logic [1:0]  we;
    logic        ok, ie, fl;
    rst = 1'b1; rdAddr = '0; wrEn = '0; wrAddr = '0; wrData = '0;
    issEn = 1'b0; issAddr = '0; flush = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    for (int r = 0; r < NREG; r++) mRegs[r] = '0;
    mBusy = '0;

    for (int k = 0; k < 16; k++) begin
      applyStimulus(5'(2*k), 5'(2*k+1), 2'b00, 0, 0, 0, 0, 1'b0, 5'(k), 1'b0, 1'b0, "t1_reset_read");
      stepCycle();
    end

    applyStimulus(5, 0, 2'b01, 5, 0, 64'hDEAD_BEEF, 0, 1'b0, 0, 1'b0, 1'b0, "t2_bypass");
    stepCycle();
    applyStimulus(5, 5, 2'b00, 0, 0, 0, 0, 1'b0, 0, 1'b0, 1'b0, "t2_next");
    stepCycle();

    applyStimulus(7, 0, 2'b11, 7, 7, 64'h11, 64'h22, 1'b0, 0, 1'b0, 1'b0, "t3_dual");
    stepCycle();
    applyStimulus(7, 0, 2'b01, 0, 0, 64'h55, 0, 1'b0, 0, 1'b0, 1'b0, "t3_r0wr");
    stepCycle();
    applyStimulus(7, 0, 2'b00, 0, 0, 0, 0, 1'b0, 0, 1'b0, 1'b0, "t3_read");
    stepCycle();

    applyStimulus(3, 3, 2'b00, 0, 0, 0, 0, 1'b1, 3, 1'b0, 1'b0, "t4_iss");
    stepCycle();
    applyStimulus(3, 0, 2'b00, 0, 0, 0, 0, 1'b0, 3, 1'b0, 1'b0, "t4_busy");
    stepCycle();
    applyStimulus(3, 0, 2'b01, 3, 0, 64'h33, 0, 1'b1, 3, 1'b0, 1'b0, "t4_wb_iss");
    stepCycle();
    applyStimulus(3, 0, 2'b00, 0, 0, 0, 0, 1'b0, 3, 1'b0, 1'b0, "t4_still");
    stepCycle();
    applyStimulus(3, 0, 2'b10, 0, 3, 0, 64'h34, 1'b0, 3, 1'b0, 1'b0, "t4_wb");
    stepCycle();
    applyStimulus(3, 0, 2'b00, 0, 0, 0, 0, 1'b0, 3, 1'b0, 1'b0, "t4_clear");
    stepCycle();

    applyStimulus(1, 2, 2'b00, 0, 0, 0, 0, 1'b1, 1, 1'b0, 1'b0, "t5_iss1");
    stepCycle();
    applyStimulus(1, 2, 2'b00, 0, 0, 0, 0, 1'b1, 2, 1'b0, 1'b0, "t5_iss2");
    stepCycle();
    applyStimulus(1, 2, 2'b00, 0, 0, 0, 0, 1'b1, 9, 1'b0, 1'b0, "t5_iss9");
    stepCycle();
    applyStimulus(9, 4, 2'b00, 0, 0, 0, 0, 1'b1, 4, 1'b1, 1'b0, "t5_flush");
    stepCycle();
    applyStimulus(7, 5, 2'b00, 0, 0, 0, 0, 1'b0, 4, 1'b0, 1'b0, "t5_after");
    stepCycle();

    applyStimulus(6, 0, 2'b00, 0, 0, 0, 0, 1'b1, 6, 1'b0, 1'b0, "t6_iss");
    stepCycle();
    applyStimulus(6, 7, 2'b11, 6, 8, 64'h66, 64'h88, 1'b0, 6, 1'b0, 1'b1, "t6_rst");
    stepCycle();
    applyStimulus(6, 7, 2'b00, 0, 0, 0, 0, 1'b0, 6, 1'b0, 1'b0, "t6_after");
    stepCycle();
    applyStimulus(5, 8, 2'b00, 0, 0, 0, 0, 1'b0, 0, 1'b0, 1'b0, "t6_regs");
    stepCycle();

    for (int n = 0; n < 80; n++) begin
      ra0 = 5'($urandom_range(0, 31));
      ra1 = 5'($urandom_range(0, 31));
      wa0 = 5'($urandom_range(0, 31));
      wa1 = ($urandom_range(0, 3) == 0) ? wa0 : 5'($urandom_range(0, 31));
      we  = 2'($urandom_range(0, 3));
      ia  = 5'($urandom_range(0, 31));
      ok  = (ia == 5'd0) || !mBusy[ia] || (we[0] && wa0 == ia) || (we[1] && wa1 == ia);
      ie  = ok && ($urandom_range(0, 1) == 1);
      fl  = ($urandom_range(0, 15) == 0);
      applyStimulus(ra0, ra1, we, wa0, wa1, {$urandom, $urandom}, {$urandom, $urandom},
                    ie, ia, fl, 1'b0, "rand");
      stepCycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
